// File: rtl/multicore_rst_seq_if.sv
// Request/reset-output bundle for multicore_rst_seq.
// The master side issues re-sequence and soft-reset requests; the slave side owns the reset outputs.
interface multicore_rst_seq_if #(
  parameter int N_CORES = 2
) ();
  logic               sys_rst_req;
  logic [N_CORES-1:0] core_rst_req;
  logic               sys_rstn;
  logic [N_CORES-1:0] core_rstn;
  logic               ready;

  modport master (
    output sys_rst_req,
    output core_rst_req,
    input  sys_rstn,
    input  core_rstn,
    input  ready
  );

  modport slave (
    input  sys_rst_req,
    input  core_rst_req,
    output sys_rstn,
    output core_rstn,
    output ready
  );
endinterface

// File: rtl/multicore_rst_seq.sv
// Power-on reset sequencer: releases the interconnect, then each core in turn, and afterwards
// services independent per-core soft-reset holds. sys_rst_req restarts the whole sequence.
module multicore_rst_seq #(
  parameter int N_CORES        = 2,
  parameter int POR_CYCLES     = 100,
  parameter int STAGGER_CYCLES = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  multicore_rst_seq_if.slave    bus
);

  localparam logic [1:0] ST_POR_WAIT = 2'd0;
  localparam logic [1:0] ST_STAGGER  = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam longint SEQ_TOTAL = longint'(POR_CYCLES) + longint'(N_CORES) * longint'(STAGGER_CYCLES);
  localparam longint CNT_MAX   = (longint'(1) << CNT_WIDTH) - longint'(1);

  localparam logic [CNT_WIDTH-1:0] POR_END = CNT_WIDTH'(POR_CYCLES);
  localparam logic [CNT_WIDTH-1:0] SEQ_END = CNT_WIDTH'(SEQ_TOTAL);
  localparam logic [HOLD_W-1:0]    HOLD_LD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_1  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]    HOLD_0  = HOLD_W'(0);

  // Refuse to build a sequencer whose counter cannot reach the final core release.
  generate
    if (SEQ_TOTAL > CNT_MAX || N_CORES < 1 || N_CORES > 16 || POR_CYCLES < 1 ||
        STAGGER_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
      $error("multicore_rst_seq: illegal parameters or CNT_WIDTH too small for sequence");
    end
  endgenerate

  // Edge count (since sequence start) at which core k leaves reset.
  function automatic logic [CNT_WIDTH-1:0] rel_edge(input int k);
    return CNT_WIDTH'(POR_CYCLES + (k + 1) * STAGGER_CYCLES);
  endfunction

  logic [1:0]                     state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]           cnt_inc_s;
  logic                           sys_rstn_q, sys_rstn_d;
  logic [N_CORES-1:0]             core_rstn_q, core_rstn_d;
  logic                           ready_q, ready_d;
  logic [N_CORES-1:0][HOLD_W-1:0] hold_q, hold_d;

  assign cnt_inc_s = cnt_q + CNT_WIDTH'(1);

  // Next-state logic: re-sequence request outranks everything, then per-state sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sys_rstn_d  = sys_rstn_q;
    core_rstn_d = core_rstn_q;
    ready_d     = ready_q;
    hold_d      = hold_q;

    if (bus.sys_rst_req) begin
      state_d     = ST_POR_WAIT;
      cnt_d       = '0;
      sys_rstn_d  = 1'b0;
      core_rstn_d = '0;
      ready_d     = 1'b0;
      hold_d      = '0;
    end else begin
      case (state_q)
        ST_POR_WAIT: begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == POR_END) begin
            sys_rstn_d = 1'b1;
            state_d    = ST_STAGGER;
          end else begin
            sys_rstn_d = 1'b0;
            state_d    = ST_POR_WAIT;
          end
        end

        ST_STAGGER: begin
          cnt_d = cnt_inc_s;
          for (int k = 0; k < N_CORES; k++) begin
            if (cnt_inc_s == rel_edge(k)) begin
              core_rstn_d[k] = 1'b1;
            end else begin
              core_rstn_d[k] = core_rstn_q[k];
            end
          end
          if (cnt_inc_s == SEQ_END) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_STAGGER;
            ready_d = 1'b0;
          end
        end

        ST_RUN: begin
          // A request (re)loads the full hold; release happens on the edge the count hits one.
          for (int k = 0; k < N_CORES; k++) begin
            if (bus.core_rst_req[k]) begin
              hold_d[k]      = HOLD_LD;
              core_rstn_d[k] = 1'b0;
            end else if (hold_q[k] == HOLD_1) begin
              hold_d[k]      = HOLD_0;
              core_rstn_d[k] = 1'b1;
            end else if (hold_q[k] != HOLD_0) begin
              hold_d[k]      = hold_q[k] - HOLD_1;
              core_rstn_d[k] = 1'b0;
            end else begin
              hold_d[k]      = HOLD_0;
              core_rstn_d[k] = 1'b1;
            end
          end
        end

        default: begin
          state_d     = ST_POR_WAIT;
          cnt_d       = '0;
          sys_rstn_d  = 1'b0;
          core_rstn_d = '0;
          ready_d     = 1'b0;
          hold_d      = '0;
        end
      endcase
    end
  end

  // State and output registers; rstn forces every reset output asserted without a clock.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_POR_WAIT;
      cnt_q       <= '0;
      sys_rstn_q  <= 1'b0;
      core_rstn_q <= '0;
      ready_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rstn_q  <= sys_rstn_d;
      core_rstn_q <= core_rstn_d;
      ready_q     <= ready_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.sys_rstn  = sys_rstn_q;
  assign bus.core_rstn = core_rstn_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_multicore_rst_seq.sv
// Self-checking bench for multicore_rst_seq: an edge-count/deadline model checked every cycle,
// directed power-on, hold, re-sequence and async-reset scenarios, then randomized traffic.
module tb_multicore_rst_seq;

  localparam int N       = 2;
  localparam int POR     = 100;
  localparam int STG     = 4;
  localparam int HOLD    = 8;
  localparam int SEQ_END = POR + N * STG;

  logic clk;
  logic rstn;

  multicore_rst_seq_if #(.N_CORES(N)) bus ();

  multicore_rst_seq #(
    .N_CORES(N), .POR_CYCLES(POR), .STAGGER_CYCLES(STG), .HOLD_CYCLES(HOLD), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests;
  int     fails;
  // Model: edges counted since the sequence (re)started, absolute edge index, per-core hold deadline.
  int     n_edges;
  longint cyc;
  longint hold_until [N];

  function automatic logic [N+1:0] model_out();
    logic [N+1:0] v;
    v[N+1] = (n_edges >= POR);
    for (int k = 0; k < N; k++)
      v[k+1] = (n_edges >= POR + (k + 1) * STG) && (cyc >= hold_until[k]);
    v[0] = (n_edges >= SEQ_END);
    return v;
  endfunction

  function automatic logic [N+1:0] dut_out();
    return {bus.sys_rstn, bus.core_rstn, bus.ready};
  endfunction

  task automatic model_clear();
    n_edges = 0;
    for (int k = 0; k < N; k++) hold_until[k] = 0;
  endtask

  task automatic model_edge();
    cyc++;
    if (!rstn) begin
      model_clear();
    end else if (bus.sys_rst_req) begin
      model_clear();
    end else begin
      if (n_edges >= SEQ_END)
        for (int k = 0; k < N; k++)
          if (bus.core_rst_req[k]) hold_until[k] = cyc + HOLD;
      if (n_edges < SEQ_END) n_edges++;
    end
  endtask

  task automatic compare();
    logic [N+1:0] got;
    logic [N+1:0] exp;
    got = dut_out();
    exp = model_out();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL model_cmp cycle %0d: got {sys,core,ready}=%b expected %b", cyc, got, exp);
    end
  endtask

  task automatic chk_lit(input string name, input logic [N+1:0] exp);
    logic [N+1:0] got;
    got = dut_out();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got {sys,core,ready}=%b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #2;
    model_clear();
    compare();
    chk_lit("async_rst", 4'b0000);
  endtask

  // Expects rstn to have just been released between edges; checks the full release sequence.
  task automatic power_on(input string name);
    for (int e = 1; e <= 108; e++) begin
      tick();
      case (e)
        99:      chk_lit({name, "_e99"},  4'b0000);
        100:     chk_lit({name, "_e100"}, 4'b1000);
        103:     chk_lit({name, "_e103"}, 4'b1000);
        104:     chk_lit({name, "_e104"}, 4'b1010);
        105:     chk_lit({name, "_e105_ign"}, 4'b1010);
        107:     chk_lit({name, "_e107"}, 4'b1010);
        108:     chk_lit({name, "_e108"}, 4'b1111);
        default: ;
      endcase
      if (e >= 40 && e < 60)  bus.core_rst_req = 2'b11;
      else if (e == 104)      bus.core_rst_req = 2'b01;
      else                    bus.core_rst_req = 2'b00;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    model_clear();
    rstn             = 1'b0;
    bus.sys_rst_req  = 1'b0;
    bus.core_rst_req = 2'b00;
    #2;
    compare();
    chk_lit("reset_state", 4'b0000);
    repeat (3) tick();

    // Power-on sequence, requests ignored before RUN.
    rstn = 1'b1;
    power_on("por1");
    repeat (3) tick();

    // Single soft reset on core 1.
    bus.core_rst_req = 2'b10;
    tick();
    bus.core_rst_req = 2'b00;
    chk_lit("hold1_e0", 4'b1011);
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 7) chk_lit("hold1_e7", 4'b1011);
      if (j == 8) chk_lit("hold1_e8", 4'b1111);
    end

    // Retriggered hold on core 0: pulses at E and E+5.
    bus.core_rst_req = 2'b01;
    tick();
    bus.core_rst_req = 2'b00;
    for (int j = 1; j <= 13; j++) begin
      tick();
      bus.core_rst_req = (j == 4) ? 2'b01 : 2'b00;
      if (j == 8)  chk_lit("retrig_e8",  4'b1101);
      if (j == 12) chk_lit("retrig_e12", 4'b1101);
      if (j == 13) chk_lit("retrig_e13", 4'b1111);
    end

    // Simultaneous holds on both cores.
    bus.core_rst_req = 2'b11;
    tick();
    bus.core_rst_req = 2'b00;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 7) chk_lit("both_e7", 4'b1001);
      if (j == 8) chk_lit("both_e8", 4'b1111);
    end

    // Re-sequence request during STAGGER at edge 102.
    async_reset();
    tick();
    rstn = 1'b1;
    for (int e = 1; e <= 101; e++) tick();
    bus.sys_rst_req = 1'b1;
    tick();
    bus.sys_rst_req = 1'b0;
    chk_lit("reseq_e102", 4'b0000);
    for (int e = 103; e <= 210; e++) begin
      tick();
      if (e == 104) chk_lit("reseq_e104", 4'b0000);
      if (e == 201) chk_lit("reseq_e201", 4'b0000);
      if (e == 202) chk_lit("reseq_e202", 4'b1000);
      if (e == 206) chk_lit("reseq_e206", 4'b1010);
      if (e == 210) chk_lit("reseq_e210", 4'b1111);
    end

    // Async reset mid-RUN, requests while in reset, then a full repeat of power-on.
    repeat (2) tick();
    async_reset();
    bus.core_rst_req = 2'b11;
    repeat (2) tick();
    rstn = 1'b1;
    power_on("por2");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      bus.core_rst_req = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
      if (bus.sys_rst_req) bus.sys_rst_req = ($urandom_range(1) == 0);
      else                 bus.sys_rst_req = ($urandom_range(499) == 0);
      if (rstn && $urandom_range(1499) == 0) async_reset();
      else if (!rstn && $urandom_range(2) == 0) rstn = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
